// File: rtl/line_buffer4_if.sv
// Pixel stream in, four-pixel vertical column out, for line_buffer4.
// Latency: n/a (signal bundle only).
// Backpressure: none; the source owns i_*, the buffer owns o_*.
interface line_buffer4_if #(
    parameter int COL_W = 12
);
    logic [7:0]       i_pixel_data;
    logic             i_pixel_valid;
    logic             i_sof;
    logic [7:0]       o_line0;
    logic [7:0]       o_line1;
    logic [7:0]       o_line2;
    logic [7:0]       o_line3;
    logic [1:0]       o_sel;
    logic             o_valid;
    logic [COL_W-1:0] o_col;

    // Pixel source side: drives the stream, observes the column.
    modport master (
        output i_pixel_data, i_pixel_valid, i_sof,
        input  o_line0, o_line1, o_line2, o_line3, o_sel, o_valid, o_col
    );

    // Line buffer side.
    modport slave (
        input  i_pixel_data, i_pixel_valid, i_sof,
        output o_line0, o_line1, o_line2, o_line3, o_sel, o_valid, o_col
    );
endinterface

// File: rtl/line_buffer4.sv
// Four-line circular pixel buffer: emits the new pixel plus the three pixels above it.
// Latency: 1 clock from accepting edge to column outputs.
// Backpressure: none; every i_pixel_valid cycle is accepted, o_valid is a per-pixel strobe.
module line_buffer4 #(
    parameter int IMG_WIDTH = 512,
    parameter int COL_W     = 12
) (
    input  logic          clk,
    input  logic          rst,
    line_buffer4_if.slave bus
);
    // Address width actually needed to index one line memory.
    localparam int              AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    // Write-position state.
    logic [COL_W-1:0] r_col;
    logic [1:0]       r_wr_line;
    logic [1:0]       r_filled;

    // Registered outputs.
    logic [7:0]       r_line [4];
    logic [1:0]       r_sel;
    logic [COL_W-1:0] r_ocol;
    logic             r_valid;

    // Effective position of the pixel on the bus (SOF forces row 0, col 0).
    logic             w_accept;
    logic [COL_W-1:0] w_col;
    logic [1:0]       w_slot;
    logic [1:0]       w_filled;
    logic [AW-1:0]    w_addr;

    // Next-state values.
    logic [COL_W-1:0] w_col_nxt;
    logic [1:0]       w_wr_line_nxt;
    logic [1:0]       w_filled_nxt;

    // Old RAM contents at the current column and the column about to be registered.
    logic [7:0]       w_rd       [4];
    logic [7:0]       w_line_nxt [4];

    assign w_accept = bus.i_pixel_valid;
    assign w_addr   = w_col[AW-1:0];

    // SOF restarts the frame: the accepted pixel lands at slot 0, col 0 with nothing filled.
    always_comb begin
        w_col    = r_col;
        w_slot   = r_wr_line;
        w_filled = r_filled;
        if (bus.i_sof) begin
            w_col    = '0;
            w_slot   = 2'd0;
            w_filled = 2'd0;
        end
    end

    // Advance the column; at end of row move to the next slot and count the finished row.
    always_comb begin
        w_col_nxt     = r_col;
        w_wr_line_nxt = r_wr_line;
        w_filled_nxt  = r_filled;
        if (w_accept) begin
            if (w_col == LAST_COL) begin
                w_col_nxt     = '0;
                w_wr_line_nxt = w_slot + 2'd1;
                w_filled_nxt  = (w_filled == 2'd3) ? 2'd3 : w_filled + 2'd1;
            end else begin
                w_col_nxt     = w_col + COL_ONE;
                w_wr_line_nxt = w_slot;
                w_filled_nxt  = w_filled;
            end
        end
    end

    // One memory per line slot; only the slot being written sees a write enable.
    for (genvar g = 0; g < 4; g++) begin : g_line
        logic [7:0] r_mem [IMG_WIDTH];

        // Store the accepted pixel into this slot when it is the write slot.
        always_ff @(posedge clk) begin
            if (w_accept && (w_slot == 2'(g))) begin
                r_mem[w_addr] <= bus.i_pixel_data;
            end
        end

        assign w_rd[g] = r_mem[w_addr];

        // The written slot takes the incoming pixel directly; the others show the rows above.
        assign w_line_nxt[g] = (w_slot == 2'(g)) ? bus.i_pixel_data : w_rd[g];
    end

    // Write-position state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col     <= '0;
            r_wr_line <= 2'd0;
            r_filled  <= 2'd0;
        end else begin
            r_col     <= w_col_nxt;
            r_wr_line <= w_wr_line_nxt;
            r_filled  <= w_filled_nxt;
        end
    end

    // Column output register: data/sel/col hold when idle, valid strobes once per pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_line[k] <= 8'h00;
            end
            r_sel   <= 2'd0;
            r_ocol  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int k = 0; k < 4; k++) begin
                    r_line[k] <= w_line_nxt[k];
                end
                r_sel  <= w_slot;
                r_ocol <= w_col;
            end
            r_valid <= w_accept && (w_filled == 2'd3);
        end
    end

    assign bus.o_line0 = r_line[0];
    assign bus.o_line1 = r_line[1];
    assign bus.o_line2 = r_line[2];
    assign bus.o_line3 = r_line[3];
    assign bus.o_sel   = r_sel;
    assign bus.o_col   = r_ocol;
    assign bus.o_valid = r_valid;
endmodule

// File: tb/tb_line_buffer4.sv
// Directed bench for line_buffer4: reset, first column, slot wrap, gaps, mid-frame SOF, width 2.
// Latency: outputs sampled on the falling edge after each accepting rising edge.
// Backpressure: none; the bench drives one pixel or one idle cycle per clock.
module tb_line_buffer4;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    line_buffer4_if #(.COL_W(3)) bus4 ();
    line_buffer4_if #(.COL_W(1)) bus2 ();

    line_buffer4 #(.IMG_WIDTH(4), .COL_W(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    line_buffer4 #(.IMG_WIDTH(2), .COL_W(1)) u_w2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] line_of(input int s);
        case (s)
            0:       return bus4.o_line0;
            1:       return bus4.o_line1;
            2:       return bus4.o_line2;
            default: return bus4.o_line3;
        endcase
    endfunction

    // One clock with the given inputs; returns at the following falling edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic s);
        bus4.i_pixel_valid = v;
        bus4.i_pixel_data  = d;
        bus4.i_sof         = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected column for frame row r, col c, pixel value {base+r, c}.
    // Row r lives in slot r%4; slot s holds row r-k with k = (r - s) mod 4, known once k <= r.
    task automatic check_px(input int r, input int c, input int base, input bit idle);
        logic [7:0] exp_px;
        int         k;
        check(idle ? "idle_valid" : "valid", 32'(bus4.o_valid), idle ? 32'd0 : 32'(r >= 3));
        check("sel", 32'(bus4.o_sel), 32'(r % 4));
        check("col", 32'(bus4.o_col), 32'(c));
        for (int s = 0; s < 4; s++) begin
            k = ((r % 4) - s + 4) % 4;
            if (k <= r) begin
                exp_px = {4'(base + r - k), 4'(c)};
                check($sformatf("line%0d r%0d c%0d", s, r, c), 32'(line_of(s)), 32'(exp_px));
            end
        end
    endtask

    task automatic send(input int r, input int c, input int base, input logic s);
        drive(1'b1, {4'(base + r), 4'(c)}, s);
        check_px(r, c, base, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus4.i_pixel_valid = 1'b0;
        bus4.i_pixel_data  = 8'h00;
        bus4.i_sof         = 1'b0;
        bus2.i_pixel_valid = 1'b0;
        bus2.i_pixel_data  = 8'h00;
        bus2.i_sof         = 1'b0;

        #1;
        check("rst_valid", 32'(bus4.o_valid), 32'd0);
        check("rst_line0", 32'(bus4.o_line0), 32'd0);
        check("rst_w2_valid", 32'(bus2.o_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Partial stream, then asynchronous reset between edges.
        for (int c = 0; c < 4; c++) send(0, c, 0, 1'b0);
        send(1, 0, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_line1", 32'(bus4.o_line1), 32'd0);
        check("arst_line0", 32'(bus4.o_line0), 32'd0);
        check("arst_sel", 32'(bus4.o_sel), 32'd0);
        check("arst_col", 32'(bus4.o_col), 32'd0);
        check("arst_valid", 32'(bus4.o_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Rows 0..2 never valid; row 3 is the first full column, row 4 wraps to slot 0.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) begin
                send(r, c, 0, 1'b0);
                if (r == 3 && c == 0) begin
                    check("first_valid", 32'(bus4.o_valid), 32'd1);
                    check("first_l0", 32'(bus4.o_line0), 32'h00);
                    check("first_l1", 32'(bus4.o_line1), 32'h10);
                    check("first_l2", 32'(bus4.o_line2), 32'h20);
                    check("first_l3", 32'(bus4.o_line3), 32'h30);
                    check("first_sel", 32'(bus4.o_sel), 32'd3);
                end
                if (r == 4 && c == 2) begin
                    check("wrap_l0", 32'(bus4.o_line0), 32'h42);
                    check("wrap_l1", 32'(bus4.o_line1), 32'h12);
                    check("wrap_l2", 32'(bus4.o_line2), 32'h22);
                    check("wrap_l3", 32'(bus4.o_line3), 32'h32);
                    check("wrap_sel", 32'(bus4.o_sel), 32'd0);
                    check("wrap_col", 32'(bus4.o_col), 32'd2);
                    check("wrap_valid", 32'(bus4.o_valid), 32'd1);
                end
            end
        end

        // New frame with random 1-3 idle cycles after every pixel, including row boundaries.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) begin
                int gap;
                send(r, c, 0, (r == 0 && c == 0));
                gap = int'($urandom_range(1, 3));
                for (int g = 0; g < gap; g++) begin
                    drive(1'b0, 8'hEE, 1'b1);
                    check_px(r, c, 0, 1'b1);
                end
            end
        end

        // Mid-frame SOF at old row 1 col 2; new frame data tagged with rows 8..11.
        for (int c = 0; c < 4; c++) send(0, c, 0, (c == 0));
        send(1, 0, 0, 1'b0);
        send(1, 1, 0, 1'b0);
        send(0, 0, 8, 1'b1);
        check("sof_l0", 32'(bus4.o_line0), 32'h80);
        check("sof_valid", 32'(bus4.o_valid), 32'd0);
        for (int n = 1; n < 16; n++) begin
            send(n / 4, n % 4, 8, 1'b0);
            if (n == 12) begin
                check("sof13_valid", 32'(bus4.o_valid), 32'd1);
                check("sof13_sel", 32'(bus4.o_sel), 32'd3);
                check("sof13_l0", 32'(bus4.o_line0), 32'h80);
                check("sof13_l1", 32'(bus4.o_line1), 32'h90);
                check("sof13_l2", 32'(bus4.o_line2), 32'hA0);
                check("sof13_l3", 32'(bus4.o_line3), 32'hB0);
            end
        end
        drive(1'b0, 8'h00, 1'b0);

        // Width 2: slot advances every 2 pixels, first valid is the 7th pixel.
        for (int n = 0; n < 10; n++) begin
            logic [7:0] got_line;
            bus2.i_pixel_valid = 1'b1;
            bus2.i_pixel_data  = 8'(n + 1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("w2_valid n%0d", n), 32'(bus2.o_valid), 32'(n >= 6));
            check($sformatf("w2_col n%0d", n), 32'(bus2.o_col), 32'(n % 2));
            check($sformatf("w2_sel n%0d", n), 32'(bus2.o_sel), 32'((n / 2) % 4));
            case ((n / 2) % 4)
                0:       got_line = bus2.o_line0;
                1:       got_line = bus2.o_line1;
                2:       got_line = bus2.o_line2;
                default: got_line = bus2.o_line3;
            endcase
            check($sformatf("w2_newest n%0d", n), 32'(got_line), 32'(n + 1));
        end
        bus2.i_pixel_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
